radix4_fft_sequencer: RTL and testbench

//  Sequences one radix-4 DIF butterfly datapath through a full N-point in-place FFT, N = 4**LOG4N.

---
 rtl/radix4_fft_sequencer_if.sv | 33 +++
 rtl/radix4_fft_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_radix4_fft_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/radix4_fft_sequencer_if.sv
// Control and memory-address bus of the radix-4 FFT sequencer.
// master: the sequencer side (takes start, drives status and addresses).
// slave : the host / RAM / twiddle-ROM side.
interface radix4_fft_sequencer_if #(
  parameter int LOG4N = 3
);
  localparam int ADDR_W = 2 * LOG4N;
  localparam int SW     = (LOG4N > 1) ? $clog2(LOG4N) : 1;

  logic                   start;
  logic                   busy;
  logic                   done;
  logic [SW-1:0]          stage;
  logic                   rd_bank;
  logic                   wr_bank;
  logic                   rd_en;
  logic [3:0][ADDR_W-1:0] rd_addr;
  logic [3:1][ADDR_W-1:0] tw_addr;
  logic                   wr_en;
  logic [3:0][ADDR_W-1:0] wr_addr;

  modport master (
    input  start,
    output busy, done, stage, rd_bank, wr_bank,
    output rd_en, rd_addr, tw_addr, wr_en, wr_addr
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_bank, wr_bank,
    input  rd_en, rd_addr, tw_addr, wr_en, wr_addr
  );
endinterface

// File: rtl/radix4_fft_sequencer.sv
// Radix-4 DIF FFT sequencer: walks one butterfly per cycle through LOG4N
// stages of an N = 4**LOG4N point in-place transform, issuing operand reads,
// twiddle exponents and, PIPE_LAT cycles later, the matching writes.
// Optional feature: define RADIX4_DIGITREV_EN to digit-reverse the last
// stage's write addresses so the result lands in natural order.

// One butterfly leg: operand address base + LANE*span and its write target.
module r4_addr_lane #(
  parameter int LOG4N = 3,
  parameter int LANE  = 0
) (
  input  logic [2*LOG4N-1:0] base,
  input  logic [2*LOG4N-1:0] span,
  input  logic               rev_en,
  output logic [2*LOG4N-1:0] rd,
  output logic [2*LOG4N-1:0] wr
);
  localparam int ADDR_W = 2 * LOG4N;

  logic [ADDR_W-1:0] rev;

  // leg address, plus base-4 digit reversal of it for the final-stage write
  always_comb begin
    rd  = base + span * ADDR_W'(LANE);
    rev = '0;
    for (int d = 0; d < LOG4N; d++) rev[2*d +: 2] = rd[2*(LOG4N-1-d) +: 2];
    wr  = rev_en ? rev : rd;
  end
endmodule

module radix4_fft_sequencer #(
  parameter int LOG4N    = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  radix4_fft_sequencer_if.master bus
);
  localparam int ADDR_W = 2 * LOG4N;
  localparam int SW     = (LOG4N > 1) ? $clog2(LOG4N) : 1;
  localparam int NB     = 4 ** (LOG4N - 1);           // butterflies per stage
  localparam int DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  typedef struct packed {
    logic                   en;
    logic                   bank;
    logic [3:0][ADDR_W-1:0] addr;
  } wr_t;

  state_t        state_q, state_d;
  addr_t         b_q, b_d;
  logic [SW-1:0] s_q, s_d;
  logic [DW-1:0] d_q, d_d;
  logic          issue_d;

  addr_t                  span, lmask, base, k;
  logic                   rev_en;
  logic [3:0][ADDR_W-1:0] rd_nxt, wr_nxt;

  logic                   busy_q, done_q, rd_en_q;
  logic [SW-1:0]          stage_q;
  logic [3:0][ADDR_W-1:0] rd_addr_q, wr_pre_q;
  logic [3:1][ADDR_W-1:0] tw_q;
  wr_t                    wr_in;
  wr_t                    wr_pipe [1:PIPE_LAT];

  // FSM and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      s_q     <= s_d;
      d_q     <= d_d;
    end
  end

  // next state: issue N/4 butterflies, drain the datapath, next stage or finish
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    s_d     = s_q;
    d_d     = '0;
    case (state_q)
      IDLE:  if (bus.start) begin
               state_d = ISSUE;
               b_d     = '0;
               s_d     = '0;
             end
      ISSUE: if (b_q == addr_t'(NB - 1)) begin
               state_d = DRAIN;
               b_d     = '0;
             end else begin
               b_d = b_q + addr_t'(1);
             end
      DRAIN: if (d_q == DW'(PIPE_LAT - 1)) begin
               if (s_q == SW'(LOG4N - 1)) begin
                 state_d = FIN;
               end else begin
                 state_d = ISSUE;
                 s_d     = s_q + SW'(1);
               end
             end else begin
               d_d = d_q + DW'(1);
             end
      FIN:   begin
               state_d = IDLE;
               s_d     = '0;
             end
      default: state_d = IDLE;
    endcase
  end

  assign issue_d = (state_d == ISSUE);

  // butterfly geometry for the next issued butterfly: span L = 4**(LOG4N-1-s)
  always_comb begin
    int sh;
    sh    = 2 * (LOG4N - 1 - int'(s_d));
    span  = addr_t'(1) << sh;
    lmask = span - addr_t'(1);
    base  = ((b_d >> sh) << (sh + 2)) | (b_d & lmask);
    k     = (b_d & lmask) << (2 * int'(s_d));
  end

`ifdef RADIX4_DIGITREV_EN
  assign rev_en = (s_d == SW'(LOG4N - 1));
`else
  assign rev_en = 1'b0;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_lane
    r4_addr_lane #(.LOG4N(LOG4N), .LANE(i)) u_lane (
      .base   (base),
      .span   (span),
      .rev_en (rev_en),
      .rd     (rd_nxt[i]),
      .wr     (wr_nxt[i])
    );
  end

  // registered status and read-side outputs, aligned with the FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stage_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_pre_q  <= '0;
      tw_q      <= '0;
    end else begin
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == FIN);
      stage_q   <= s_d;
      rd_en_q   <= issue_d;
      rd_addr_q <= issue_d ? rd_nxt : '0;
      wr_pre_q  <= issue_d ? wr_nxt : '0;
      tw_q[1]   <= issue_d ? k : '0;
      tw_q[2]   <= issue_d ? (k << 1) : '0;
      tw_q[3]   <= issue_d ? (k + (k << 1)) : '0;
    end
  end

  assign wr_in.en   = rd_en_q;
  assign wr_in.bank = rd_en_q & ~stage_q[0];
  assign wr_in.addr = wr_pre_q;

  // write-side delay line matching the datapath latency; reset drops in-flight writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= PIPE_LAT; i++) wr_pipe[i] <= '0;
    end else begin
      wr_pipe[1] <= wr_in;
      for (int i = 2; i <= PIPE_LAT; i++) wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.stage   = stage_q;
  assign bus.rd_bank = stage_q[0];
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.tw_addr = tw_q;
  assign bus.wr_en   = wr_pipe[PIPE_LAT].en;
  assign bus.wr_bank = wr_pipe[PIPE_LAT].bank;
  assign bus.wr_addr = wr_pipe[PIPE_LAT].addr;
endmodule

// File: tb/tb_radix4_fft_sequencer.sv
// Bench for radix4_fft_sequencer (LOG4N=3, PIPE_LAT=2): cycle-accurate model
// derived from the timing/addressing formulas plus directed literal checks.
module tb_radix4_fft_sequencer;
  localparam int LOG4N  = 3;
  localparam int P      = 2;
  localparam int NB     = 16;
  localparam int T_DONE = LOG4N * (NB + P) + 1;

  logic clk = 1'b0;
  logic rst;

  radix4_fft_sequencer_if #(.LOG4N(LOG4N)) bus();

  radix4_fft_sequencer #(.LOG4N(LOG4N), .PIPE_LAT(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int run_t0   = -1;
  int last_rst = -1000;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int pow4(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 4;
    return r;
  endfunction

  function automatic int drev(input int a);
    int r, v;
    r = 0;
    v = a;
    for (int d = 0; d < LOG4N; d++) begin
      r = r * 4 + v % 4;
      v = v / 4;
    end
    return r;
  endfunction

  function automatic int op_addr(input int s, input int b, input int i);
    int l;
    l = NB / pow4(s);
    return (b / l) * 4 * l + (b % l) + i * l;
  endfunction

  function automatic int tw_exp(input int s, input int b, input int m);
    int l;
    l = NB / pow4(s);
    return m * (b % l) * pow4(s);
  endfunction

  function automatic bit idle_at(input int x);
    return (run_t0 < 0) || ((x - run_t0) > T_DONE);
  endfunction

  // read port expectation in cycle x of the current run
  function automatic void rd_at(input int x, output bit en, output int s, output int b);
    int rel;
    en = 1'b0;
    s  = 0;
    b  = 0;
    if (run_t0 >= 0) begin
      rel = x - run_t0;
      if (rel >= 1 && rel <= LOG4N * (NB + P)) begin
        s  = (rel - 1) / (NB + P);
        b  = (rel - 1) % (NB + P);
        en = (b < NB);
      end
    end
  endfunction

  // model state: which cycle the running transform was started in
  always @(posedge clk) begin
    if (rst) begin
      run_t0   <= -1;
      last_rst <= cyc;
    end else if (bus.start && idle_at(cyc)) begin
      run_t0 <= cyc;
    end
    cyc <= cyc + 1;
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    bit en, wen;
    int s, b, ws, wb, rel, a;
    if (cyc >= 1) begin
      rel = (run_t0 < 0) ? -1 : cyc - run_t0;
      chk("busy", int'(bus.busy), int'(rel >= 1 && rel <= T_DONE));
      chk("done", int'(bus.done), int'(rel == T_DONE));
      if (rel == T_DONE) chk("done_stage", int'(bus.stage), LOG4N - 1);
      rd_at(cyc, en, s, b);
      chk("rd_en", int'(bus.rd_en), int'(en));
      if (en) begin
        chk("stage", int'(bus.stage), s);
        chk("rd_bank", int'(bus.rd_bank), s % 2);
        for (int i = 0; i < 4; i++) chk("rd_addr", int'(bus.rd_addr[i]), op_addr(s, b, i));
        for (int m = 1; m < 4; m++) chk("tw_addr", int'(bus.tw_addr[m]), tw_exp(s, b, m));
      end
      wen = 1'b0;
      ws  = 0;
      wb  = 0;
      if (cyc - P > last_rst) rd_at(cyc - P, wen, ws, wb);
      chk("wr_en", int'(bus.wr_en), int'(wen));
      if (wen) begin
        chk("wr_bank", int'(bus.wr_bank), 1 - ws % 2);
        for (int i = 0; i < 4; i++) begin
          a = op_addr(ws, wb, i);
`ifdef RADIX4_DIGITREV_EN
          if (ws == LOG4N - 1) a = drev(a);
`endif
          chk("wr_addr", int'(bus.wr_addr[i]), a);
        end
      end
    end
  end

  task automatic at_cyc(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic lit_rd(input string nm, input int a0, input int a1, input int a2, input int a3);
    chk({nm, ".rd0"}, int'(bus.rd_addr[0]), a0);
    chk({nm, ".rd1"}, int'(bus.rd_addr[1]), a1);
    chk({nm, ".rd2"}, int'(bus.rd_addr[2]), a2);
    chk({nm, ".rd3"}, int'(bus.rd_addr[3]), a3);
  endtask

  task automatic lit_wr(input string nm, input int a0, input int a1, input int a2, input int a3);
    chk({nm, ".wr0"}, int'(bus.wr_addr[0]), a0);
    chk({nm, ".wr1"}, int'(bus.wr_addr[1]), a1);
    chk({nm, ".wr2"}, int'(bus.wr_addr[2]), a2);
    chk({nm, ".wr3"}, int'(bus.wr_addr[3]), a3);
  endtask

  task automatic lit_tw(input string nm, input int t1, input int t2, input int t3);
    chk({nm, ".tw1"}, int'(bus.tw_addr[1]), t1);
    chk({nm, ".tw2"}, int'(bus.tw_addr[2]), t2);
    chk({nm, ".tw3"}, int'(bus.tw_addr[3]), t3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, c3;
    rst       = 1'b1;
    bus.start = 1'b1;               // START during reset must be ignored
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.start = 1'b0;
    at_cyc(2);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.done", int'(bus.done), 0);
    chk("rst.rd_en", int'(bus.rd_en), 0);
    chk("rst.wr_en", int'(bus.wr_en), 0);
    lit_rd("rst", 0, 0, 0, 0);
    lit_wr("rst", 0, 0, 0, 0);
    lit_tw("rst", 0, 0, 0);

    // first transform
    @(posedge clk); #1 bus.start = 1'b1; c = cyc;
    @(posedge clk); #1 bus.start = 1'b0;
    at_cyc(c + 1);
    chk("s0b0.rd_en", int'(bus.rd_en), 1);
    chk("s0b0.busy", int'(bus.busy), 1);
    lit_rd("s0b0", 0, 16, 32, 48);
    lit_tw("s0b0", 0, 0, 0);
    at_cyc(c + 2);
    chk("s0.wr_en_early", int'(bus.wr_en), 0);
    at_cyc(c + 3);
    chk("s0b0.wr_en", int'(bus.wr_en), 1);
    chk("s0b0.wr_bank", int'(bus.wr_bank), 1);
    lit_wr("s0b0", 0, 16, 32, 48);
    at_cyc(c + 6);
    lit_rd("s0b5", 5, 21, 37, 53);
    lit_tw("s0b5", 5, 10, 15);
    at_cyc(c + 8);
    lit_wr("s0b5", 5, 21, 37, 53);
    at_cyc(c + 9);
    @(posedge clk); #1 bus.start = 1'b1;   // cycle c+10: must be ignored
    @(posedge clk); #1 bus.start = 1'b0;
    at_cyc(c + 16);
    chk("s0.last_rd", int'(bus.rd_en), 1);
    at_cyc(c + 17);
    chk("drain0.rd_en", int'(bus.rd_en), 0);
    at_cyc(c + 18);
    chk("s0.last_wr", int'(bus.wr_en), 1);
    at_cyc(c + 19);
    chk("s1b0.wr_en", int'(bus.wr_en), 0);
    chk("s1b0.rd_en", int'(bus.rd_en), 1);
    chk("s1b0.rd_bank", int'(bus.rd_bank), 1);
    chk("s1b0.stage", int'(bus.stage), 1);
    lit_rd("s1b0", 0, 4, 8, 12);
    at_cyc(c + 24);
    lit_rd("s1b5", 17, 21, 25, 29);
    lit_tw("s1b5", 4, 8, 12);
    at_cyc(c + 26);
    chk("s1b5.wr_bank", int'(bus.wr_bank), 0);
    lit_wr("s1b5", 17, 21, 25, 29);
    at_cyc(c + 36);
    chk("drain1.rd_en", int'(bus.rd_en), 0);
    at_cyc(c + 37);
    chk("s2b0.rd_en", int'(bus.rd_en), 1);
    chk("s2b0.stage", int'(bus.stage), 2);
    at_cyc(c + 42);
    lit_rd("s2b5", 20, 21, 22, 23);
    lit_tw("s2b5", 0, 0, 0);
    at_cyc(c + 44);
    chk("s2b5.wr_bank", int'(bus.wr_bank), 1);
`ifdef RADIX4_DIGITREV_EN
    lit_wr("s2b5", 5, 21, 37, 53);
`else
    lit_wr("s2b5", 20, 21, 22, 23);
`endif
    at_cyc(c + 54);
    chk("pre_done.done", int'(bus.done), 0);
    chk("pre_done.wr_en", int'(bus.wr_en), 1);
    at_cyc(c + 55);
    chk("done.done", int'(bus.done), 1);
    chk("done.busy", int'(bus.busy), 1);
    chk("done.wr_en", int'(bus.wr_en), 0);

    // back-to-back START in the cycle after DONE
    @(posedge clk); #1 bus.start = 1'b1; c2 = cyc;
    at_cyc(c2);
    chk("post_done.busy", int'(bus.busy), 0);
    chk("post_done.done", int'(bus.done), 0);
    @(posedge clk); #1 bus.start = 1'b0;
    at_cyc(c2 + 1);
    chk("b2b.rd_en", int'(bus.rd_en), 1);
    lit_rd("b2b", 0, 16, 32, 48);

    // reset mid-transform at relative cycle 25
    at_cyc(c2 + 24);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    at_cyc(c2 + 26);
    chk("midrst.busy", int'(bus.busy), 0);
    chk("midrst.rd_en", int'(bus.rd_en), 0);
    chk("midrst.wr_en", int'(bus.wr_en), 0);
    chk("midrst.stage", int'(bus.stage), 0);
    lit_rd("midrst", 0, 0, 0, 0);
    lit_wr("midrst", 0, 0, 0, 0);
    lit_tw("midrst", 0, 0, 0);
    at_cyc(c2 + 30);
    chk("midrst.wr_quiet", int'(bus.wr_en), 0);

    // restart after reset
    @(posedge clk); #1 bus.start = 1'b1; c3 = cyc;
    @(posedge clk); #1 bus.start = 1'b0;
    at_cyc(c3 + 1);
    chk("restart.stage", int'(bus.stage), 0);
    lit_rd("restart", 0, 16, 32, 48);
    at_cyc(c3 + 3);
    lit_wr("restart", 0, 16, 32, 48);
    at_cyc(c3 + T_DONE + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
